// File: rtl/axi2mem_pkg.sv
// Shared constants and types for the axi2mem read-side TCDM engine.
package axi2mem_pkg;

    localparam int unsigned NUM_LANES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BEAT_BYTES = NUM_LANES * WORD_BYTES;
    localparam int unsigned ID_WIDTH   = 6;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_BURST = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/axi2mem_rd_resp_fifo.sv
// Per-lane response FIFO: registered storage (no fall-through), exports occupancy
// so the issue logic can compute credits.
module axi2mem_rd_resp_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  empty_o,
    output logic [AW:0]           occ_o
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [AW-1:0]                    wr_ptr_q, rd_ptr_q;
    logic [AW:0]                      cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    assign dat_o   = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign occ_o   = cnt_q;

    // Credit-based issue must never let a response arrive into a full FIFO.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop_i && (cnt_q == (AW+1)'(DEPTH))));
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && (cnt_q == '0)));

endmodule

// File: rtl/axi2mem_tcdm_rd_unit.sv
// Read-side TCDM engine: one burst at a time, two independent 32-bit lanes, credit-limited issue.
// Optional AXI2MEM_RD_PERF_EN adds a saturating TCDM stall-cycle counter output.
//   state    | meaning
//   RD_IDLE  | waiting for a burst command (cmd_gnt_o high)
//   RD_BURST | lanes issuing TCDM reads as credit allows
//   RD_DRAIN | all reads granted, emptying response FIFOs
module axi2mem_tcdm_rd_unit
    import axi2mem_pkg::*;
#(
    parameter int unsigned RESP_DEPTH = 4,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
`ifdef AXI2MEM_RD_PERF_EN
    output logic [31:0]                          perf_stall_cnt_o,
`endif
    input  logic                                 cmd_req_i,
    output logic                                 cmd_gnt_o,
    input  logic [31:0]                          cmd_add_i,
    input  logic [LEN_WIDTH-1:0]                 cmd_len_i,
    input  logic [ID_WIDTH-1:0]                  cmd_id_i,
    output logic                                 busy_o,
    output logic [NUM_LANES-1:0]                 tcdm_req_o,
    output logic [NUM_LANES-1:0][31:0]           tcdm_add_o,
    output logic [NUM_LANES-1:0]                 tcdm_wen_o,
    output logic [NUM_LANES-1:0][3:0]            tcdm_be_o,
    input  logic [NUM_LANES-1:0]                 tcdm_gnt_i,
    input  logic [NUM_LANES-1:0][31:0]           tcdm_r_rdata_i,
    input  logic [NUM_LANES-1:0]                 tcdm_r_valid_i,
    output logic [NUM_LANES-1:0][31:0]           rd_data_push_dat_o,
    output logic [NUM_LANES-1:0]                 rd_data_push_req_o,
    input  logic [NUM_LANES-1:0]                 rd_data_push_gnt_i,
    output logic [ID_WIDTH-1:0]                  rd_data_push_id_o,
    output logic                                 rd_data_push_last_o
);

    localparam int unsigned CW = LEN_WIDTH + 1;
    localparam int unsigned OW = $clog2(RESP_DEPTH) + 1;

    rd_state_e state_q, state_d;

    logic [31:0]          add_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [ID_WIDTH-1:0]  id_q;
    logic [CW-1:0]        beats;
    logic                 cmd_hs;

    logic [NUM_LANES-1:0] issue_done, pop_done;

    assign cmd_gnt_o  = (state_q == RD_IDLE);
    assign busy_o     = (state_q != RD_IDLE);
    assign cmd_hs     = cmd_req_i & cmd_gnt_o;
    assign beats      = CW'(len_q) + CW'(1);
    assign tcdm_wen_o = '1;
    assign tcdm_be_o  = '1;
    assign rd_data_push_id_o = id_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE:  if (cmd_req_i) state_d = RD_BURST;
            RD_BURST: if (&issue_done) state_d = RD_DRAIN;
            RD_DRAIN: if (&pop_done && !(|rd_data_push_req_o)) state_d = RD_IDLE;
            default:  state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RD_IDLE;
            add_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            if (cmd_hs) begin
                add_q <= cmd_add_i & ~32'h7;
                len_q <= cmd_len_i;
                id_q  <= cmd_id_i;
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [CW-1:0] issue_cnt_q, pop_cnt_q;
        logic          inflight_q;
        logic          fifo_push, fifo_pop, fifo_empty;
        logic [OW-1:0] fifo_occ;
        logic [OW:0]   used;

        // A slot is spoken for from grant until pop, so responses can never overflow.
        assign used          = (OW+1)'(fifo_occ) + (OW+1)'(inflight_q);
        assign issue_done[g] = (issue_cnt_q == beats);
        assign pop_done[g]   = (pop_cnt_q == beats);
        assign tcdm_req_o[g] = (state_q == RD_BURST) && !issue_done[g]
                               && (used < (OW+1)'(RESP_DEPTH));
        assign tcdm_add_o[g] = tcdm_req_o[g]
                               ? add_q + 32'(issue_cnt_q) * 32'(BEAT_BYTES) + 32'(g) * 32'(WORD_BYTES)
                               : '0;

        // Responses not matched by an own grant (e.g. left over across a reset) are dropped.
        assign fifo_push = tcdm_r_valid_i[g] & inflight_q;
        assign fifo_pop  = rd_data_push_req_o[g] & rd_data_push_gnt_i[g];
        assign rd_data_push_req_o[g] = ~fifo_empty;

        axi2mem_rd_resp_fifo #(
            .DATA_WIDTH (32),
            .DEPTH      (RESP_DEPTH)
        ) i_resp_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (fifo_push),
            .dat_i   (tcdm_r_rdata_i[g]),
            .pop_i   (fifo_pop),
            .dat_o   (rd_data_push_dat_o[g]),
            .empty_o (fifo_empty),
            .occ_o   (fifo_occ)
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                issue_cnt_q <= '0;
                pop_cnt_q   <= '0;
                inflight_q  <= 1'b0;
            end else begin
                inflight_q <= tcdm_req_o[g] & tcdm_gnt_i[g];
                if (cmd_hs) begin
                    issue_cnt_q <= '0;
                    pop_cnt_q   <= '0;
                end else begin
                    if (tcdm_req_o[g] && tcdm_gnt_i[g]) issue_cnt_q <= issue_cnt_q + 1'b1;
                    if (fifo_pop) pop_cnt_q <= pop_cnt_q + 1'b1;
                end
            end
        end

        if (g == 0) begin : g_last
            assign rd_data_push_last_o = rd_data_push_req_o[0] && (pop_cnt_q == CW'(len_q));
        end
    end

`ifdef AXI2MEM_RD_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (cmd_hs) begin
            stall_cnt_q <= '0;
        end else if (|(tcdm_req_o & ~tcdm_gnt_i) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axi2mem_tcdm_rd_unit.sv
// Directed + randomized bench for axi2mem_tcdm_rd_unit with a beat-counting reference model.
module tb_axi2mem_tcdm_rd_unit;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              cmd_req_i;
    logic              cmd_gnt_o;
    logic [31:0]       cmd_add_i;
    logic [7:0]        cmd_len_i;
    logic [5:0]        cmd_id_i;
    logic              busy_o;
    logic [1:0]        tcdm_req_o;
    logic [1:0][31:0]  tcdm_add_o;
    logic [1:0]        tcdm_wen_o;
    logic [1:0][3:0]   tcdm_be_o;
    logic [1:0]        tcdm_gnt_i;
    logic [1:0][31:0]  tcdm_r_rdata_i;
    logic [1:0]        tcdm_r_valid_i;
    logic [1:0][31:0]  rd_data_push_dat_o;
    logic [1:0]        rd_data_push_req_o;
    logic [1:0]        rd_data_push_gnt_i;
    logic [5:0]        rd_data_push_id_o;
    logic              rd_data_push_last_o;
    logic [31:0]       perf;

    axi2mem_tcdm_rd_unit #(.RESP_DEPTH(4), .LEN_WIDTH(8)) dut (
`ifdef AXI2MEM_RD_PERF_EN
        .perf_stall_cnt_o    (perf),
`endif
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .cmd_req_i           (cmd_req_i),
        .cmd_gnt_o           (cmd_gnt_o),
        .cmd_add_i           (cmd_add_i),
        .cmd_len_i           (cmd_len_i),
        .cmd_id_i            (cmd_id_i),
        .busy_o              (busy_o),
        .tcdm_req_o          (tcdm_req_o),
        .tcdm_add_o          (tcdm_add_o),
        .tcdm_wen_o          (tcdm_wen_o),
        .tcdm_be_o           (tcdm_be_o),
        .tcdm_gnt_i          (tcdm_gnt_i),
        .tcdm_r_rdata_i      (tcdm_r_rdata_i),
        .tcdm_r_valid_i      (tcdm_r_valid_i),
        .rd_data_push_dat_o  (rd_data_push_dat_o),
        .rd_data_push_req_o  (rd_data_push_req_o),
        .rd_data_push_gnt_i  (rd_data_push_gnt_i),
        .rd_data_push_id_o   (rd_data_push_id_o),
        .rd_data_push_last_o (rd_data_push_last_o)
    );

    always #5 clk_i = ~clk_i;

`ifndef AXI2MEM_RD_PERF_EN
    assign perf = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: burst = base + beat count; lane i beat k lives at base + 8k + 4i.
    logic [31:0] base;
    int          beats;
    logic [5:0]  exp_id;
    int          grants [2];
    int          pops   [2];
    bit          hs;
    bit          in_burst;
    int          stall_exp;
    bit   [1:0]  prev_wait;
    logic [31:0] prev_addr [2];
    logic [1:0]  nxt_rv;
    logic [31:0] nxt_rd [2];
    logic [1:0]  gnt_val, pgnt_val;
    bit          gnt_rand, pgnt_rand;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        bit stall;
        nxt_rv = '0;
        stall  = |(tcdm_req_o & ~tcdm_gnt_i);
`ifdef AXI2MEM_RD_PERF_EN
        chk("perf_stall", perf, stall_exp);
`endif
        if (in_burst && (pops[0] < beats || pops[1] < beats)) chk("busy_in_burst", busy_o, 1);
        if (!rd_data_push_req_o[0]) chk("last_idle", rd_data_push_last_o, 0);
        for (int i = 0; i < 2; i++) begin
            if (prev_wait[i]) begin
                chk("req_hold", tcdm_req_o[i], 1);
                chk("addr_hold", tcdm_add_o[i], prev_addr[i]);
            end
            if (tcdm_req_o[i] && tcdm_gnt_i[i]) begin
                chk("grant_in_range", 32'(grants[i] < beats), 1);
                chk("tcdm_add", tcdm_add_o[i], base + 32'(8 * grants[i]) + 32'(4 * i));
                chk("credit_limit", 32'(grants[i] - pops[i] < 4), 1);
                nxt_rv[i] = 1'b1;
                nxt_rd[i] = memf(tcdm_add_o[i]);
                grants[i]++;
            end
            prev_wait[i] = tcdm_req_o[i] & ~tcdm_gnt_i[i];
            prev_addr[i] = tcdm_add_o[i];
            if (rd_data_push_req_o[i] && rd_data_push_gnt_i[i]) begin
                chk("push_in_range", 32'(pops[i] < grants[i]), 1);
                chk("push_dat", rd_data_push_dat_o[i], memf(base + 32'(8 * pops[i]) + 32'(4 * i)));
                chk("push_id", rd_data_push_id_o, exp_id);
                if (i == 0) chk("push_last", rd_data_push_last_o, 32'(pops[0] == beats - 1));
                pops[i]++;
            end
        end
        if (cmd_req_i && cmd_gnt_o) begin
            base      = cmd_add_i & ~32'h7;
            beats     = int'(cmd_len_i) + 1;
            exp_id    = cmd_id_i;
            grants    = '{0, 0};
            pops      = '{0, 0};
            hs        = 1'b1;
            stall_exp = 0;
        end else if (stall) begin
            stall_exp++;
        end
    endtask

    task automatic apply();
        for (int i = 0; i < 2; i++) begin
            tcdm_r_valid_i[i]     = nxt_rv[i];
            tcdm_r_rdata_i[i]     = nxt_rv[i] ? nxt_rd[i] : $urandom;
            tcdm_gnt_i[i]         = gnt_rand  ? 1'($urandom_range(0, 1)) : gnt_val[i];
            rd_data_push_gnt_i[i] = pgnt_rand ? 1'($urandom_range(0, 1)) : pgnt_val[i];
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        observe();
        in_burst = in_burst | hs;
        @(posedge clk_i);
        #1;
        apply();
    endtask

    task automatic send_cmd(input logic [31:0] a, input int len, input logic [5:0] id);
        int n = 0;
        cmd_req_i = 1'b1;
        cmd_add_i = a;
        cmd_len_i = 8'(len);
        cmd_id_i  = id;
        hs        = 1'b0;
        while (!hs && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_accept", 32'(hs), 1);
        cmd_req_i = 1'b0;
        cmd_add_i = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_o || pops[0] < beats || pops[1] < beats) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_in_time", 32'(n < 400), 1);
        chk("lane0_pops", pops[0], beats);
        chk("lane1_pops", pops[1], beats);
        chk("busy_end", busy_o, 0);
        chk("cmd_gnt_end", cmd_gnt_o, 1);
        in_burst = 1'b0;
        hs       = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        cmd_req_i = 1'b0; cmd_add_i = '0; cmd_len_i = '0; cmd_id_i = '0;
        tcdm_gnt_i = '0; tcdm_r_rdata_i = '0; tcdm_r_valid_i = '0; rd_data_push_gnt_i = '0;
        base = '0; beats = 0; exp_id = '0; grants = '{0, 0}; pops = '{0, 0};
        hs = 0; in_burst = 0; stall_exp = 0; prev_wait = '0; nxt_rv = '0;
        nxt_rd = '{32'h0, 32'h0}; prev_addr = '{32'h0, 32'h0};
        gnt_val = 2'b11; pgnt_val = 2'b11; gnt_rand = 0; pgnt_rand = 0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("rst_cmd_gnt", cmd_gnt_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_req", tcdm_req_o, 0);
        chk("rst_add", tcdm_add_o, 0);
        chk("rst_push_req", rd_data_push_req_o, 0);
        chk("rst_id", rd_data_push_id_o, 0);
        chk("rst_last", rd_data_push_last_o, 0);
        chk("wen_const", tcdm_wen_o, 2'b11);
        chk("be_const", tcdm_be_o, 8'hFF);
        chk("rst_perf", perf, 0);
        apply();

        // Basic burst with minimum latency checks.
        send_cmd(32'h1000, 3, 6'd5);
        chk("lat_req_cycle1", tcdm_req_o, 2'b11);
        tick();
        chk("lat_no_push_cycle2", rd_data_push_req_o, 2'b00);
        tick();
        chk("lat_push_cycle3", rd_data_push_req_o, 2'b11);
        wait_idle();

        // Push side stalled: credits cap outstanding beats at the FIFO depth.
        pgnt_val = 2'b00;
        send_cmd(32'h3000, 7, 6'd9);
        repeat (12) tick();
        chk("credit_grants_l0", grants[0], 4);
        chk("credit_grants_l1", grants[1], 4);
        chk("credit_req_low", tcdm_req_o, 2'b00);
        pgnt_val = 2'b11;
        wait_idle();

        // Lane 1 grant withheld; lane 0 must complete on its own.
        gnt_val = 2'b01;
        send_cmd(32'h4000, 1, 6'd2);
        repeat (4) tick();
        chk("skew_l0_pops", pops[0], 2);
        chk("skew_l1_grants", grants[1], 0);
        chk("skew_busy", busy_o, 1);
        gnt_val = 2'b11;
        tcdm_gnt_i = 2'b11;
        wait_idle();

        // Single beat with unaligned start address.
        send_cmd(32'h2007, 0, 6'h3F);
        chk("len0_add_l0", tcdm_add_o[0], 32'h2000);
        chk("len0_add_l1", tcdm_add_o[1], 32'h2004);
        wait_idle();

        // Lane 0 grant low for three request cycles.
        gnt_val = 2'b10;
        send_cmd(32'h5000, 0, 6'd1);
        repeat (3) tick();
        gnt_val = 2'b11;
        tcdm_gnt_i = 2'b11;
        wait_idle();
`ifdef AXI2MEM_RD_PERF_EN
        chk("perf_three", perf, 3);
`endif

        // Asynchronous reset after 2 of 8 beats; pending responses must be dropped.
        send_cmd(32'h6000, 7, 6'd7);
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_cmd_gnt", cmd_gnt_o, 1);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_req", tcdm_req_o, 0);
        chk("mid_rst_add", tcdm_add_o, 0);
        chk("mid_rst_push_req", rd_data_push_req_o, 0);
        chk("mid_rst_id", rd_data_push_id_o, 0);
        chk("mid_rst_last", rd_data_push_last_o, 0);
        rst_ni = 1'b1;
        beats = 0; grants = '{0, 0}; pops = '{0, 0};
        in_burst = 0; hs = 0; stall_exp = 0; prev_wait = '0;
        #1;
        tick();
        chk("stale_resp_dropped", rd_data_push_req_o, 2'b00);
        send_cmd(32'h7000, 1, 6'd11);
        wait_idle();

        // Randomized bursts with random grants on both sides.
        gnt_rand = 1; pgnt_rand = 1;
        for (int t = 0; t < 8; t++) begin
            send_cmd($urandom, int'($urandom_range(0, 15)), 6'($urandom));
            wait_idle();
        end
        gnt_rand = 0; pgnt_rand = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
